// File: rtl/pbvi_pkg.sv
// Shared sizes, element types and controller states for the PBVI iteration loop.
package pbvi_pkg;

  localparam int NUM_POINTS  = 16;
  localparam int NUM_STATES  = 2;
  localparam int NUM_ACTIONS = 3;
  localparam int W           = 16;
  localparam int IDX_W       = $clog2(NUM_POINTS);

  typedef logic [W-1:0] alpha_t;
  typedef logic [1:0]   action_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK,
    ST_UPDATE,
    ST_DONE
  } ctrl_state_e;

  // Widen by one bit so the sign of the difference is visible, then fold to magnitude.
  function automatic alpha_t abs_diff(alpha_t a, alpha_t b);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[W]) d = -d;
    return d[W-1:0];
  endfunction

endpackage

// File: rtl/pbvi_conv_check.sv
// Running maximum of per-state absolute alpha change, one belief point per step.
module pbvi_conv_check
  import pbvi_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           step,
  input  logic [NUM_STATES-1:0][W-1:0]   cur,
  input  logic [NUM_STATES-1:0][W-1:0]   nxt,
  output logic [W-1:0]                   maxdiff
);

  alpha_t step_max;
  alpha_t d;

  always_comb begin
    step_max = maxdiff;
    d        = '0;
    for (int s = 0; s < NUM_STATES; s++) begin
      d = abs_diff(nxt[s], cur[s]);
      if (d > step_max) step_max = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maxdiff <= '0;
    end else if (clear) begin
      maxdiff <= '0;
    end else if (step) begin
      maxdiff <= step_max;
    end
  end

endmodule

// File: rtl/pbvi_loop_ctrl.sv
// Closes the PBVI value-iteration loop around step123: issue, capture, convergence
// check over all points, then either re-issue or stop with the final policy.
module pbvi_loop_ctrl
  import pbvi_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start,
  input  logic [7:0]                                  max_iter,
  input  logic [W-1:0]                                epsilon,
  input  logic [NUM_POINTS-1:0][NUM_STATES-1:0][W-1:0] alpha_init,
  input  logic                                        en_loop,
  input  logic [NUM_POINTS-1:0][NUM_STATES-1:0][W-1:0] alpha_new,
  input  logic [NUM_POINTS-1:0][1:0]                  action_new,
  output logic                                        en_step,
  output logic [NUM_POINTS-1:0][NUM_STATES-1:0][W-1:0] alpha_cur,
  output logic [NUM_POINTS-1:0][1:0]                  policy,
  output logic [7:0]                                  iter_count,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        converged,
  output logic                                        timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  ctrl_state_e state, state_nxt;

  logic [NUM_POINTS-1:0][NUM_STATES-1:0][W-1:0] alpha_nxt;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] wait_cnt;
  logic [W-1:0]     maxdiff;

  logic       start_ok, wait_expired, last_point, within_eps, iter_limit;
  logic [7:0] iter_max;
  logic [8:0] iter_inc;

  assign start_ok     = start && (state == ST_IDLE || state == ST_DONE);
  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign last_point   = (idx == IDX_W'(NUM_POINTS - 1));
  assign within_eps   = (maxdiff <= epsilon);
  assign iter_max     = (max_iter == 8'd0) ? 8'd1 : max_iter;
  assign iter_inc     = {1'b0, iter_count} + 9'd1;
  assign iter_limit   = (iter_inc >= {1'b0, iter_max});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start_ok) state_nxt = ST_ISSUE;
      ST_ISSUE:         state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (en_loop)           state_nxt = ST_CHECK;
        else if (wait_expired) state_nxt = ST_DONE;
      end
      ST_CHECK:         if (last_point) state_nxt = ST_UPDATE;
      // maxdiff is registered, so by UPDATE it already includes the last point.
      ST_UPDATE:        state_nxt = (within_eps || iter_limit) ? ST_DONE : ST_ISSUE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    en_step = (state == ST_ISSUE);
    busy    = (state == ST_ISSUE) || (state == ST_WAIT) ||
              (state == ST_CHECK) || (state == ST_UPDATE);
    done    = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alpha_cur   <= '0;
      alpha_nxt   <= '0;
      policy      <= '0;
      iter_count  <= '0;
      idx         <= '0;
      wait_cnt    <= '0;
      converged   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            alpha_cur   <= alpha_init;
            iter_count  <= '0;
            converged   <= 1'b0;
            timeout_err <= 1'b0;
          end
        end
        ST_ISSUE: wait_cnt <= '0;
        ST_WAIT: begin
          if (en_loop) begin
            alpha_nxt <= alpha_new;
            policy    <= action_new;
            idx       <= '0;
          end else if (!wait_expired) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end else begin
            timeout_err <= 1'b1;
            converged   <= 1'b0;
          end
        end
        ST_CHECK: idx <= idx + IDX_W'(1);
        ST_UPDATE: begin
          alpha_cur  <= alpha_nxt;
          iter_count <= (iter_count == 8'hFF) ? 8'hFF : iter_inc[7:0];
          converged  <= within_eps;
        end
        default: ;
      endcase
    end
  end

  pbvi_conv_check u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == ST_WAIT && en_loop),
    .step    (state == ST_CHECK),
    .cur     (alpha_cur[idx]),
    .nxt     (alpha_nxt[idx]),
    .maxdiff (maxdiff)
  );

endmodule

// File: tb/tb_pbvi_loop_ctrl.sv
// Scoreboard bench for pbvi_loop_ctrl with a behavioural step123 stand-in.
module tb_pbvi_loop_ctrl;
  import pbvi_pkg::*;

  localparam int TIMEOUT = 32;
  localparam int LAT     = 2;

  typedef logic [NUM_POINTS-1:0][NUM_STATES-1:0][W-1:0] aset_t;
  typedef logic [NUM_POINTS-1:0][1:0] pol_t;

  typedef struct {
    string      name;
    logic       conv;
    logic       tout;
    logic [7:0] iters;
    pol_t       pol;
    aset_t      alpha;
    int         pulses;
    int         pulseBase;
    int         latency;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] max_iter = '0;
  logic [W-1:0] epsilon = '0;
  aset_t      alpha_init = '0;
  logic       en_loop;
  aset_t      alpha_new;
  pol_t       action_new;
  logic       en_step;
  aset_t      alpha_cur;
  pol_t       policy;
  logic [7:0] iter_count;
  logic       busy, done, converged, timeout_err;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails = 0;
  int   cycle = 0;
  int   pulses = 0;
  int   lastIssue = 0;
  int   callIdx = 0;
  int   manReq = 0;
  int   manDone = 0;
  int   dP = 0, dS = 0, dVal = 0;
  bit   silent = 1'b0;
  pol_t lastPolicy = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  pbvi_loop_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .max_iter    (max_iter),
    .epsilon     (epsilon),
    .alpha_init  (alpha_init),
    .en_loop     (en_loop),
    .alpha_new   (alpha_new),
    .action_new  (action_new),
    .en_step     (en_step),
    .alpha_cur   (alpha_cur),
    .policy      (policy),
    .iter_count  (iter_count),
    .busy        (busy),
    .done        (done),
    .converged   (converged),
    .timeout_err (timeout_err)
  );

  function automatic pol_t policyFor(int k);
    pol_t r;
    for (int p = 0; p < NUM_POINTS; p++) r[p] = action_t'((p + k) % 3);
    return r;
  endfunction

  function automatic aset_t makeInit(int base);
    aset_t r;
    for (int p = 0; p < NUM_POINTS; p++)
      for (int s = 0; s < NUM_STATES; s++)
        r[p][s] = alpha_t'(base + 16 * p + s);
    return r;
  endfunction

  task automatic checkOutput(string name, logic [511:0] act, logic [511:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // step123 stand-in: answers each en_step LAT cycles later with a perturbed copy of alpha_cur.
  initial begin : step123_model
    aset_t nxt;
    en_loop    = 1'b0;
    alpha_new  = '0;
    action_new = '0;
    forever begin
      @(negedge clk);
      if (manReq != manDone) begin
        manDone    = manReq;
        en_loop    = 1'b1;
        alpha_new  = {(NUM_POINTS * NUM_STATES){16'h5A5A}};
        action_new = '1;
        @(negedge clk);
        en_loop = 1'b0;
      end else if (en_step && !silent) begin
        repeat (LAT) @(negedge clk);
        nxt = alpha_cur;
        nxt[dP][dS] = alpha_cur[dP][dS] + alpha_t'(dVal);
        alpha_new  = nxt;
        action_new = policyFor(callIdx);
        callIdx++;
        en_loop = 1'b1;
        @(negedge clk);
        en_loop    = 1'b0;
        alpha_new  = {(NUM_POINTS * NUM_STATES){16'hA5A5}};
        action_new = '1;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    logic doneQ;
    doneQ = 1'b0;
    forever begin
      @(negedge clk);
      if (en_step) begin
        pulses++;
        lastIssue = cycle;
      end
      if (done && !doneQ) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpected_done: got done=1, required no completion");
        end else begin
          e = expQ.pop_front();
          checkOutput({e.name, "_converged"}, 512'(converged), 512'(e.conv));
          checkOutput({e.name, "_timeout_err"}, 512'(timeout_err), 512'(e.tout));
          checkOutput({e.name, "_iter_count"}, 512'(iter_count), 512'(e.iters));
          checkOutput({e.name, "_policy"}, 512'(policy), 512'(e.pol));
          checkOutput({e.name, "_alpha_cur"}, 512'(alpha_cur), 512'(e.alpha));
          checkOutput({e.name, "_en_step_pulses"}, 512'(pulses - e.pulseBase), 512'(e.pulses));
          checkOutput({e.name, "_latency"}, 512'(cycle - lastIssue), 512'(e.latency));
        end
      end
      doneQ = done;
    end
  end

  task automatic applyStimulus(string name, int base, logic [7:0] mi, logic [W-1:0] eps,
                               int dp, int ds, int dv, bit quiet, bit expConv,
                               int expIters, int expLat, bit inject);
    exp_t  e;
    aset_t init;
    init = makeInit(base);
    @(negedge clk);
    silent = quiet;
    dP = dp;
    dS = ds;
    dVal = dv;
    e.name  = name;
    e.conv  = expConv;
    e.tout  = quiet;
    e.iters = 8'(expIters);
    e.alpha = init;
    if (!quiet) begin
      e.alpha[dp][ds] = init[dp][ds] + alpha_t'(dv * expIters);
      e.pol = policyFor(callIdx + expIters - 1);
    end else begin
      e.pol = lastPolicy;
    end
    lastPolicy  = e.pol;
    e.pulses    = quiet ? 1 : expIters;
    e.pulseBase = pulses;
    e.latency   = expLat;
    alpha_init  = init;
    max_iter    = mi;
    epsilon     = eps;
    start       = 1'b1;
    expQ.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (inject) begin
      for (int k = 0; k < 100 && !en_loop; k++) @(posedge clk);
      repeat (3) @(negedge clk);
      start      = 1'b1;
      alpha_init = '0;
      max_iter   = 8'd1;
      @(negedge clk);
      start      = 1'b0;
      alpha_init = init;
      max_iter   = mi;
    end
    for (int k = 0; k < 600 && expQ.size() != 0; k++) @(negedge clk);
    if (expQ.size() != 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL %s_completion: got no done within budget, required done", name);
      expQ.delete();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_en_step", 512'(en_step), 512'(0));
    checkOutput("reset_busy", 512'(busy), 512'(0));
    checkOutput("reset_done", 512'(done), 512'(0));
    checkOutput("reset_converged", 512'(converged), 512'(0));
    checkOutput("reset_timeout_err", 512'(timeout_err), 512'(0));
    checkOutput("reset_iter_count", 512'(iter_count), 512'(0));
    checkOutput("reset_policy", 512'(policy), 512'(0));
    checkOutput("reset_alpha_cur", 512'(alpha_cur), 512'(0));

    manReq = manReq + 1;
    repeat (4) @(negedge clk);
    checkOutput("idle_en_loop_busy", 512'(busy), 512'(0));
    checkOutput("idle_en_loop_done", 512'(done), 512'(0));
    checkOutput("idle_en_loop_policy", 512'(policy), 512'(0));
    checkOutput("idle_en_loop_pulses", 512'(pulses), 512'(0));

    //            name          base  mi    eps       dp  ds  dv     quiet conv iters lat inject
    applyStimulus("fixed",      1000, 8'd10, 16'd0,    0,  0,  0,     1'b0, 1'b1, 1,  20, 1'b0);
    applyStimulus("nonconv",    2000, 8'd3,  16'd4,    15, 1,  5,     1'b0, 1'b0, 3,  20, 1'b1);
    applyStimulus("eq_eps",     3000, 8'd10, 16'd4,    0,  0,  4,     1'b0, 1'b1, 1,  20, 1'b0);
    applyStimulus("above_eps",  3000, 8'd2,  16'd3,    0,  0,  4,     1'b0, 1'b0, 2,  20, 1'b0);
    applyStimulus("neg_maxit0", 4000, 8'd0,  16'd5,    7,  0,  -6,    1'b0, 1'b0, 1,  20, 1'b0);
    applyStimulus("eps_max",    1000, 8'd5,  16'hFFFF, 3,  1,  -1000, 1'b0, 1'b1, 1,  20, 1'b0);
    applyStimulus("timeout",    6000, 8'd5,  16'd0,    0,  0,  0,     1'b1, 1'b0, 0,  33, 1'b0);

    @(negedge clk);
    silent     = 1'b1;
    alpha_init = makeInit(5000);
    max_iter   = 8'd4;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 512'(busy), 512'(0));
    checkOutput("midreset_done", 512'(done), 512'(0));
    checkOutput("midreset_en_step", 512'(en_step), 512'(0));
    checkOutput("midreset_policy", 512'(policy), 512'(0));
    checkOutput("midreset_alpha_cur", 512'(alpha_cur), 512'(0));
    checkOutput("midreset_timeout_err", 512'(timeout_err), 512'(0));
    @(negedge clk);
    rst_n  = 1'b1;
    manReq = manReq + 1;
    repeat (4) @(negedge clk);
    checkOutput("postreset_busy", 512'(busy), 512'(0));
    checkOutput("postreset_done", 512'(done), 512'(0));
    checkOutput("postreset_policy", 512'(policy), 512'(0));
    checkOutput("postreset_alpha_cur", 512'(alpha_cur), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
